// File: rtl/fc_dense_layer.sv
// Fully-connected dense layer: streams flattened L2 activations against a weight ROM,
// adds a bias, then rounds, applies ReLU and saturates each neuron before handing it off.
module fc_dense_layer #(
  parameter int DATA_WIDTH   = 20,
  parameter int FRAC_BITS    = 16,
  parameter int IN_LEN       = 2048,
  parameter int N_OUT        = 4,
  parameter int ADDR_WIDTH   = 12,
  parameter int W_ADDR_WIDTH = 14,
  parameter int ACC_WIDTH    = 52,
  localparam int IDX_WIDTH   = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic                    crd,
  output logic [ADDR_WIDTH-1:0]   caddr_rd,
  input  logic [DATA_WIDTH-1:0]   cdata_rd,
  output logic                    w_rd,
  output logic [W_ADDR_WIDTH-1:0] w_addr,
  input  logic [DATA_WIDTH-1:0]   w_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic [IDX_WIDTH-1:0]    out_idx
);

  typedef enum logic [2:0] {IDLE, FETCH, BIAS, FINISH, OUT, DONE} state_t;

  localparam logic signed [ACC_WIDTH-1:0] ROUND_HALF =
    {{(ACC_WIDTH-FRAC_BITS){1'b0}}, 1'b1, {(FRAC_BITS-1){1'b0}}};
  localparam logic signed [ACC_WIDTH-1:0] RES_MAX =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] SAT_VALUE = {1'b0, {(DATA_WIDTH-1){1'b1}}};

  state_t state, state_next;

  logic [IDX_WIDTH-1:0]            o_cnt;
  logic [ADDR_WIDTH-1:0]           i_cnt;
  logic signed [ACC_WIDTH-1:0]     acc;
  logic                            mac_valid;
  logic                            last_elem;
  logic                            last_neuron;
  logic signed [2*DATA_WIDTH-1:0]  prod;
  logic signed [ACC_WIDTH-1:0]     prod_ext;
  logic signed [ACC_WIDTH-1:0]     bias_ext;
  logic signed [ACC_WIDTH-1:0]     sum_biased;
  logic signed [ACC_WIDTH-1:0]     rounded;
  logic [DATA_WIDTH-1:0]           result;

  assign last_elem   = (i_cnt == ADDR_WIDTH'(IN_LEN - 1));
  assign last_neuron = (o_cnt == IDX_WIDTH'(N_OUT - 1));

  assign prod       = $signed(cdata_rd) * $signed(w_data);
  assign prod_ext   = {{(ACC_WIDTH-2*DATA_WIDTH){prod[2*DATA_WIDTH-1]}}, prod};
  assign bias_ext   = {{(ACC_WIDTH-DATA_WIDTH){w_data[DATA_WIDTH-1]}}, w_data};
  assign sum_biased = acc + (bias_ext <<< FRAC_BITS);
  assign rounded    = (sum_biased + ROUND_HALF) >>> FRAC_BITS;

  always_comb begin
    result = rounded[DATA_WIDTH-1:0];
    if (rounded[ACC_WIDTH-1]) begin
      result = '0;
    end else if (rounded > RES_MAX) begin
      result = SAT_VALUE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    crd        = 1'b0;
    w_rd       = 1'b0;
    out_valid  = 1'b0;
    caddr_rd   = '0;
    w_addr     = '0;
    case (state)
      IDLE: begin
        if (start) state_next = FETCH;
      end
      FETCH: begin
        busy     = 1'b1;
        crd      = 1'b1;
        w_rd     = 1'b1;
        caddr_rd = i_cnt;
        w_addr   = W_ADDR_WIDTH'(o_cnt) * W_ADDR_WIDTH'(IN_LEN) + W_ADDR_WIDTH'(i_cnt);
        if (last_elem) state_next = BIAS;
      end
      BIAS: begin
        busy       = 1'b1;
        w_rd       = 1'b1;
        w_addr     = W_ADDR_WIDTH'(N_OUT * IN_LEN) + W_ADDR_WIDTH'(o_cnt);
        state_next = FINISH;
      end
      FINISH: begin
        busy       = 1'b1;
        state_next = OUT;
      end
      OUT: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_next = last_neuron ? DONE : FETCH;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Read data lags the address by one cycle, so mac_valid marks cycles whose operands are live.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      o_cnt     <= '0;
      i_cnt     <= '0;
      acc       <= '0;
      mac_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
    end else begin
      mac_valid <= (state == FETCH);
      case (state)
        IDLE: begin
          if (start) begin
            o_cnt <= '0;
            i_cnt <= '0;
            acc   <= '0;
          end
        end
        FETCH: begin
          if (!last_elem) i_cnt <= i_cnt + 1'b1;
          if (mac_valid) acc <= acc + prod_ext;
        end
        BIAS: begin
          if (mac_valid) acc <= acc + prod_ext;
        end
        FINISH: begin
          out_data <= result;
          out_idx  <= o_cnt;
        end
        OUT: begin
          if (out_ready && !last_neuron) begin
            o_cnt <= o_cnt + 1'b1;
            i_cnt <= '0;
            acc   <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fc_dense_layer.sv
// Directed bench for fc_dense_layer: behavioural L2/weight memories with one-cycle latency
// and hand-computed neuron results checked through immediate assertions.
module tb_fc_dense_layer;

  localparam int IN_LEN = 2048;
  localparam int N_OUT  = 4;
  localparam int BIAS_BASE = N_OUT * IN_LEN;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        busy;
  logic        done;
  logic        crd;
  logic [11:0] caddr_rd;
  logic [19:0] cdata_rd;
  logic        w_rd;
  logic [13:0] w_addr;
  logic [19:0] w_data;
  logic        out_valid;
  logic        out_ready;
  logic [19:0] out_data;
  logic [1:0]  out_idx;

  logic [19:0] x_mem [4096];
  logic [19:0] w_mem [16384];

  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int total_cnt = 0;
  int cyc_base  = 0;
  bit proto_err;

  always #5 clk = ~clk;

  fc_dense_layer dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .crd       (crd),
    .caddr_rd  (caddr_rd),
    .cdata_rd  (cdata_rd),
    .w_rd      (w_rd),
    .w_addr    (w_addr),
    .w_data    (w_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx)
  );

  always @(posedge clk) begin
    if (crd) cdata_rd <= x_mem[caddr_rd];
    if (w_rd) w_data <= w_mem[w_addr];
  end

  // Sticky flag for reads outside the fetch window or beyond the memory bounds.
  always @(posedge clk) begin
    if (crd && caddr_rd >= 12'(IN_LEN)) proto_err <= 1'b1;
    if (w_rd && w_addr >= 14'(BIAS_BASE + N_OUT)) proto_err <= 1'b1;
    if ((crd || w_rd) && (out_valid || done || !busy)) proto_err <= 1'b1;
  end

  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt = pass_cnt + 1;
    else begin
      fail_cnt++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mem();
    for (int k = 0; k < 4096; k++) x_mem[k] = '0;
    for (int k = 0; k < 16384; k++) w_mem[k] = '0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},      32'(busy), 0);
    check({tag, "_done"},      32'(done), 0);
    check({tag, "_crd"},       32'(crd), 0);
    check({tag, "_w_rd"},      32'(w_rd), 0);
    check({tag, "_out_valid"}, 32'(out_valid), 0);
    check({tag, "_caddr"},     32'(caddr_rd), 0);
    check({tag, "_w_addr"},    32'(w_addr), 0);
    check({tag, "_out_data"},  32'(out_data), 0);
    check({tag, "_out_idx"},   32'(out_idx), 0);
  endtask

  task automatic apply_stimulus();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc_base = 1;
  endtask

  // Waits for one neuron, checks it, optionally stalls the consumer, then completes the handshake.
  task automatic check_output(input int idx, input logic [19:0] exp, input int stall);
    int cyc = cyc_base;
    while (!out_valid && cyc < IN_LEN + 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    check($sformatf("n%0d_valid", idx), 32'(out_valid), 1);
    check($sformatf("n%0d_latency", idx), cyc, IN_LEN + 3);
    check($sformatf("n%0d_idx", idx), 32'(out_idx), idx);
    check($sformatf("n%0d_data", idx), 32'(out_data), 32'(exp));
    if (stall > 0) begin
      out_ready = 1'b0;
      for (int s = 0; s < stall; s++) begin
        @(posedge clk); #1;
        check($sformatf("n%0d_hold_valid", idx), 32'(out_valid), 1);
        check($sformatf("n%0d_hold_data", idx), 32'(out_data), 32'(exp));
        check($sformatf("n%0d_hold_idx", idx), 32'(out_idx), idx);
        check($sformatf("n%0d_hold_reads", idx), {30'd0, crd, w_rd}, 0);
      end
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
    check($sformatf("n%0d_valid_drop", idx), 32'(out_valid), 0);
    if (idx < N_OUT - 1) begin
      check($sformatf("n%0d_next_crd", idx), 32'(crd), 1);
      check($sformatf("n%0d_next_caddr", idx), 32'(caddr_rd), 0);
      check($sformatf("n%0d_next_waddr", idx), 32'(w_addr), (idx + 1) * IN_LEN);
      cyc_base = 1;
    end else begin
      check("done_pulse", 32'(done), 1);
      check("done_busy", 32'(busy), 0);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check("done_single", 32'(done), 0);
      check("start_in_done_ignored", 32'(busy), 0);
    end
  endtask

  task automatic run_all(input string tag, input logic [3:0][19:0] exp, input int stall_idx);
    $display("[TB] scenario %s", tag);
    apply_stimulus();
    for (int o = 0; o < N_OUT; o++) check_output(o, exp[o], (o == stall_idx) ? 10 : 0);
  endtask

  task automatic load_half_plus_one();
    clear_mem();
    for (int k = 0; k < IN_LEN; k++) x_mem[k] = 20'h10000;
    for (int o = 0; o < N_OUT; o++) begin
      w_mem[o * IN_LEN] = 20'h10000;
      w_mem[BIAS_BASE + o] = 20'h08000;
    end
  endtask

  initial begin
    reset     = 1'b0;
    start     = 1'b0;
    out_ready = 1'b1;
    clear_mem();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("por");
    reset = 1'b1;
    @(posedge clk); #1;

    run_all("zeros", {20'h00000, 20'h00000, 20'h00000, 20'h00000}, -1);

    load_half_plus_one();
    run_all("bias_half", {20'h18000, 20'h18000, 20'h18000, 20'h18000}, -1);

    clear_mem();
    for (int k = 0; k < IN_LEN; k++) begin
      x_mem[k] = 20'h10000;
      w_mem[2 * IN_LEN + k] = 20'hF0000;
      w_mem[3 * IN_LEN + k] = 20'h10000;
    end
    w_mem[0] = 20'h10000;
    run_all("relu_sat", {20'h7FFFF, 20'h00000, 20'h00000, 20'h10000}, -1);

    clear_mem();
    x_mem[0] = 20'h00001;
    w_mem[0]            = 20'h08000;
    w_mem[IN_LEN]       = 20'h07FFF;
    w_mem[2 * IN_LEN]   = 20'hF8000;
    w_mem[3 * IN_LEN]   = 20'h18000;
    run_all("rounding", {20'h00002, 20'h00000, 20'h00000, 20'h00001}, -1);

    clear_mem();
    x_mem[IN_LEN - 1] = 20'h20000;
    for (int o = 0; o < N_OUT; o++) begin
      w_mem[o * IN_LEN + IN_LEN - 1] = 20'(32'h08000 * (o + 1));
      w_mem[BIAS_BASE + o] = 20'hFC000;
    end
    run_all("last_elem", {20'h3C000, 20'h2C000, 20'h1C000, 20'h0C000}, -1);

    $display("[TB] scenario reset_mid_fetch");
    load_half_plus_one();
    apply_stimulus();
    check_output(0, 20'h18000, 0);
    repeat (1000) @(posedge clk);
    #1;
    check("mid_caddr", 32'(caddr_rd), 1000);
    check("mid_waddr", 32'(w_addr), IN_LEN + 1000);
    reset = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check("post_reset_idle", 32'(busy), 0);

    apply_stimulus();
    check("busy_after_start", 32'(busy), 1);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    cyc_base = 3;
    check("start_while_busy_caddr", 32'(caddr_rd), 2);
    for (int o = 0; o < N_OUT; o++) check_output(o, 20'h18000, (o == 1) ? 10 : 0);

    check("protocol", 32'(proto_err), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
